// File: rtl/stack_cmd_pkg.sv
// stack_cmd_pkg
// Shared types and constants for the stack command front end.
//   DEPTH_DEF : default stack capacity
//   DEPTH_W   : width of the occupancy count (holds 0..DEPTH_DEF)
//   DATA_W    : push payload width
//   state_e   : front-end FSM state encoding (also driven out for debug)
package stack_cmd_pkg;

  localparam int DEPTH_DEF = 256;
  localparam int DEPTH_W   = 9;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/stack_cmd_frontend_if.sv
// stack_cmd_frontend_if
// Command channel between the button front end and the downstream stack.
//   cmd_push_o  : push command (front end -> stack)
//   cmd_pop_o   : pop command (front end -> stack)
//   cmd_data_o  : payload accompanying cmd_push_o
//   cmd_ready_i : stack has completed the current command (stack -> front end)
//
// Handshake: the front end raises exactly one of cmd_push_o/cmd_pop_o and
// holds it, with cmd_data_o, unchanged until a rising clock edge at which
// cmd_ready_i is 1; that edge completes the command and the front end drops
// the command on that same edge. cmd_ready_i is ignored while no command is
// outstanding.
interface stack_cmd_frontend_if;
  import stack_cmd_pkg::*;

  logic              cmd_push_o;
  logic              cmd_pop_o;
  logic [DATA_W-1:0] cmd_data_o;
  logic              cmd_ready_i;

  modport master (
    output cmd_push_o,
    output cmd_pop_o,
    output cmd_data_o,
    input  cmd_ready_i
  );

  modport slave (
    input  cmd_push_o,
    input  cmd_pop_o,
    input  cmd_data_o,
    output cmd_ready_i
  );

endinterface

// File: rtl/stack_cmd_debounce.sv
// stack_cmd_debounce
// Two-flop synchronizer for one raw button, followed by an optional
// debounce filter. Build macro: STACK_CMD_DEBOUNCE_EN.
//   clk, reset : clock, asynchronous active-high reset
//   btn_i      : raw button, asynchronous to clk
//   level_o    : synchronized (and, with the macro, debounced) level
// With STACK_CMD_DEBOUNCE_EN the output follows the synchronizer only after
// the synchronizer has disagreed with it for DEBOUNCE_CYCLES consecutive
// cycles. Without it the output is the synchronizer output directly.
module stack_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef STACK_CMD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             db_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter runs only while the input disagrees with the filtered level;
  // any agreeing cycle restarts the count, so a glitch shorter than
  // DEBOUNCE_CYCLES never reaches level_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level_o = db_q;
`else
  assign level_o = sync2_q;
`endif

endmodule

// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend
// Turns two raw push/pop buttons into single push/pop commands for a
// downstream stack, tracks stack occupancy and flags rejected commands.
// Build macro: STACK_CMD_DEBOUNCE_EN (enables per-button debounce filter).
//   clk, reset          : clock, asynchronous active-high reset
//   btn_push_i/btn_pop_i: raw buttons, asynchronous to clk
//   data_i              : push payload, captured when a push is accepted
//   err_clr_i           : synchronous clear of err_o
//   cmd_if (master)     : cmd_push_o/cmd_pop_o/cmd_data_o/cmd_ready_i
//   depth_o             : occupancy 0..DEPTH
//   full_o/empty_o      : depth_o==DEPTH / depth_o==0
//   err_o               : sticky, set by push-while-full or pop-while-empty
//   state_o             : FSM state for debug
module stack_cmd_frontend
  import stack_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_push_i,
  input  logic                btn_pop_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                err_clr_i,
  stack_cmd_frontend_if.master cmd_if,
  output logic [DEPTH_W-1:0]  depth_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                err_o,
  output state_e              state_o
);

  logic push_db, pop_db;
  logic push_prev_q, pop_prev_q;
  logic push_rise, pop_rise;

  state_e              state_q, state_d;
  logic                push_q, push_d;
  logic                pop_q, pop_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                err_q, err_d;
  logic                new_err;
  logic                full, empty;

  stack_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_push (
    .clk(clk), .reset(reset), .btn_i(btn_push_i), .level_o(push_db)
  );

  stack_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pop (
    .clk(clk), .reset(reset), .btn_i(btn_pop_i), .level_o(pop_db)
  );

  assign push_rise = push_db & ~push_prev_q;
  assign pop_rise  = pop_db & ~pop_prev_q;
  assign full      = (depth_q == DEPTH_W'(DEPTH));
  assign empty     = (depth_q == '0);

  always_comb begin
    state_d = state_q;
    push_d  = push_q;
    pop_d   = pop_q;
    data_d  = data_q;
    depth_d = depth_q;
    new_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Push has priority; a pop edge in the same cycle is dropped.
        if (push_rise) begin
          if (!full) begin
            data_d  = data_i;
            push_d  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            new_err = 1'b1;
            state_d = ST_RELEASE;
          end
        end else if (pop_rise) begin
          if (!empty) begin
            pop_d   = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            new_err = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_if.cmd_ready_i) begin
          push_d  = 1'b0;
          pop_d   = 1'b0;
          // Bounds guards keep depth in 0..DEPTH even if the command
          // somehow disagrees with the current occupancy.
          if (push_q && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
          end else if (pop_q && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
          end
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!push_db && !pop_db) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        push_d  = 1'b0;
        pop_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // A new error in the same cycle as a clear leaves the flag set.
    if (new_err) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      data_q      <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      push_prev_q <= 1'b0;
      pop_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      data_q      <= data_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      push_prev_q <= push_db;
      pop_prev_q  <= pop_db;
    end
  end

  assign cmd_if.cmd_push_o = push_q;
  assign cmd_if.cmd_pop_o  = pop_q;
  assign cmd_if.cmd_data_o = data_q;
  assign depth_o           = depth_q;
  assign full_o            = full;
  assign empty_o           = empty;
  assign err_o             = err_q;
  assign state_o           = state_q;

endmodule
